// File: rtl/sumador_pkg.sv
// sumador_pkg: shared constants and tag type for the sumador arbiter slice.
//   DATA_W_DEF : default operand width
//   ID_A/ID_B  : requester identifiers carried in the tag pipe
//   tag_t      : {vld, id} ownership tag of one in-flight operation
package sumador_pkg;
    localparam int   DATA_W_DEF = 4;
    localparam logic ID_A       = 1'b0;
    localparam logic ID_B       = 1'b1;
    typedef struct packed {
        logic vld;
        logic id;
    } tag_t;
endpackage

// File: rtl/sumador_tag_pipe.sv
// sumador_tag_pipe: PIPE_LAT-deep ownership tag shift register, async clear.
//   i_vld/i_id : tag loaded into stage 0 every edge
//   o_vld/o_id : tail stage, aligned with the adder result
//   o_any_vld  : any stage holds a valid tag
module sumador_tag_pipe
    import sumador_pkg::*;
#(
    parameter int PIPE_LAT = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_vld,
    input  logic i_id,
    output logic o_vld,
    output logic o_id,
    output logic o_any_vld
);
    tag_t [PIPE_LAT-1:0] r_tags;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tags <= '0;
        end else begin
            r_tags[0] <= {i_vld, i_id};
            for (int i = 1; i < PIPE_LAT; i++) r_tags[i] <= r_tags[i-1];
        end
    end

    assign o_vld = r_tags[PIPE_LAT-1].vld;
    assign o_id  = r_tags[PIPE_LAT-1].id;

    always_comb begin
        o_any_vld = 1'b0;
        for (int i = 0; i < PIPE_LAT; i++) o_any_vld = o_any_vld | r_tags[i].vld;
    end
endmodule

// File: rtl/sumador_arbiter.sv
// sumador_arbiter: round-robin share of one pipelined adder between requesters A and B.
//   a_*/b_* valid/ready/op1/op2 : operand handshakes from the requesters
//   add_valid_in/add_op1/add_op2 : issue to the adder, add_sum : adder result at tag tail
//   a_resp_*/b_resp_*           : one-cycle result pulse and held sum per requester
//   busy                        : operations in flight or outstanding
module sumador_arbiter
    import sumador_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int PIPE_LAT = 2,
    parameter int MAX_OUT  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [DATA_W-1:0] a_op1,
    input  logic [DATA_W-1:0] a_op2,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [DATA_W-1:0] b_op1,
    input  logic [DATA_W-1:0] b_op2,
    output logic              add_valid_in,
    output logic [DATA_W-1:0] add_op1,
    output logic [DATA_W-1:0] add_op2,
    input  logic [DATA_W:0]   add_sum,
    output logic              a_resp_valid,
    output logic [DATA_W:0]   a_resp_sum,
    output logic              b_resp_valid,
    output logic [DATA_W:0]   b_resp_sum,
    output logic              busy
);
    localparam int CNT_W = $clog2(MAX_OUT + 1);

    logic [CNT_W-1:0] r_cnt_a, r_cnt_b;
    logic             r_last;
    logic             r_a_resp_valid, r_b_resp_valid;
    logic [DATA_W:0]  r_a_resp_sum, r_b_resp_sum;
    logic             w_elig_a, w_elig_b, w_gnt_a, w_gnt_b, w_fire;
    logic             w_tail_vld, w_tail_id, w_any_tag, w_ret_a, w_ret_b;

    // Eligibility uses the registered count only; a same-cycle return does not free a slot.
    assign w_elig_a = a_valid && (r_cnt_a < CNT_W'(MAX_OUT));
    assign w_elig_b = b_valid && (r_cnt_b < CNT_W'(MAX_OUT));
    // On a tie the requester that did not win last time gets the grant.
    assign w_gnt_a  = w_elig_a && (!w_elig_b || r_last == ID_B);
    assign w_gnt_b  = w_elig_b && !w_gnt_a;
    assign w_fire   = w_gnt_a || w_gnt_b;

    assign a_ready      = w_gnt_a;
    assign b_ready      = w_gnt_b;
    assign add_valid_in = w_fire;

    always_comb begin
        add_op1 = w_gnt_a ? a_op1 : w_gnt_b ? b_op1 : '0;
        add_op2 = w_gnt_a ? a_op2 : w_gnt_b ? b_op2 : '0;
    end

    sumador_tag_pipe #(
        .PIPE_LAT (PIPE_LAT)
    ) u_tags (
        .clk       (clk),
        .reset     (reset),
        .i_vld     (w_fire),
        .i_id      (w_gnt_b ? ID_B : ID_A),
        .o_vld     (w_tail_vld),
        .o_id      (w_tail_id),
        .o_any_vld (w_any_tag)
    );

    assign w_ret_a = w_tail_vld && (w_tail_id == ID_A);
    assign w_ret_b = w_tail_vld && (w_tail_id == ID_B);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last <= ID_B;
        end else if (w_fire) begin
            r_last <= w_gnt_b ? ID_B : ID_A;
        end
    end

    // Issue and return on the same edge cancel, so the count holds.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt_a <= '0;
            r_cnt_b <= '0;
        end else begin
            if (w_gnt_a && !w_ret_a) r_cnt_a <= r_cnt_a + CNT_W'(1);
            else if (!w_gnt_a && w_ret_a) r_cnt_a <= r_cnt_a - CNT_W'(1);
            if (w_gnt_b && !w_ret_b) r_cnt_b <= r_cnt_b + CNT_W'(1);
            else if (!w_gnt_b && w_ret_b) r_cnt_b <= r_cnt_b - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a_resp_valid <= 1'b0;
            r_b_resp_valid <= 1'b0;
            r_a_resp_sum   <= '0;
            r_b_resp_sum   <= '0;
        end else begin
            r_a_resp_valid <= w_ret_a;
            r_b_resp_valid <= w_ret_b;
            if (w_ret_a) r_a_resp_sum <= add_sum;
            if (w_ret_b) r_b_resp_sum <= add_sum;
        end
    end

    assign a_resp_valid = r_a_resp_valid;
    assign b_resp_valid = r_b_resp_valid;
    assign a_resp_sum   = r_a_resp_sum;
    assign b_resp_sum   = r_b_resp_sum;
    assign busy         = w_any_tag || (r_cnt_a != '0) || (r_cnt_b != '0);
endmodule

// File: tb/tb_sumador_arbiter.sv
// tb_sumador_arbiter: directed and scoreboarded checks of sumador_arbiter with a 2-stage adder model.
module tb_sumador_arbiter;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       a_valid = 1'b0, b_valid = 1'b0;
    logic [3:0] a_op1 = '0, a_op2 = '0, b_op1 = '0, b_op2 = '0;
    logic       a_ready, b_ready, add_valid_in, a_resp_valid, b_resp_valid, busy;
    logic [3:0] add_op1, add_op2;
    logic [4:0] add_sum, a_resp_sum, b_resp_sum, s1, s2;
    logic       m_a_ready, m_b_ready, m_add_valid_in, m_a_resp_valid, m_b_resp_valid, m_busy;
    logic [3:0] m_add_op1, m_add_op2;
    logic [4:0] m_add_sum, m_a_resp_sum, m_b_resp_sum, m1, m2;
    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        s1 <= {1'b0, add_op1} + {1'b0, add_op2};
        s2 <= s1;
        m1 <= {1'b0, m_add_op1} + {1'b0, m_add_op2};
        m2 <= m1;
    end
    assign add_sum   = s2;
    assign m_add_sum = m2;

    sumador_arbiter #(.DATA_W(4), .PIPE_LAT(2), .MAX_OUT(3)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_op1(a_op1), .a_op2(a_op2),
        .b_valid(b_valid), .b_ready(b_ready), .b_op1(b_op1), .b_op2(b_op2),
        .add_valid_in(add_valid_in), .add_op1(add_op1), .add_op2(add_op2), .add_sum(add_sum),
        .a_resp_valid(a_resp_valid), .a_resp_sum(a_resp_sum),
        .b_resp_valid(b_resp_valid), .b_resp_sum(b_resp_sum), .busy(busy));

    sumador_arbiter #(.DATA_W(4), .PIPE_LAT(2), .MAX_OUT(1)) dut1 (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_ready(m_a_ready), .a_op1(a_op1), .a_op2(a_op2),
        .b_valid(b_valid), .b_ready(m_b_ready), .b_op1(b_op1), .b_op2(b_op2),
        .add_valid_in(m_add_valid_in), .add_op1(m_add_op1), .add_op2(m_add_op2), .add_sum(m_add_sum),
        .a_resp_valid(m_a_resp_valid), .a_resp_sum(m_a_resp_sum),
        .b_resp_valid(m_b_resp_valid), .b_resp_sum(m_b_resp_sum), .busy(m_busy));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        a_valid = 1'b0;
        b_valid = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        a_valid = 1'b0;
        b_valid = 1'b0;
        reset = 1'b1;
        tick();
        checks++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin errs++; $display("FAIL reset_ready got a=%b b=%b want 0 0", a_ready, b_ready); end
        checks++; if (add_valid_in !== 1'b0 || add_op1 !== 4'd0 || add_op2 !== 4'd0) begin errs++; $display("FAIL reset_add got v=%b op1=%0d op2=%0d want 0 0 0", add_valid_in, add_op1, add_op2); end
        checks++; if (a_resp_valid !== 1'b0 || b_resp_valid !== 1'b0) begin errs++; $display("FAIL reset_resp_valid got a=%b b=%b want 0 0", a_resp_valid, b_resp_valid); end
        checks++; if (a_resp_sum !== 5'd0 || b_resp_sum !== 5'd0) begin errs++; $display("FAIL reset_resp_sum got a=%0d b=%0d want 0 0", a_resp_sum, b_resp_sum); end
        checks++; if (busy !== 1'b0 || m_busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b/%b want 0", busy, m_busy); end
        reset = 1'b0;
    endtask

    task automatic test_a_only();
        do_reset();
        a_valid = 1'b1; a_op1 = 4'd3; a_op2 = 4'd4;
        #1;
        checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin errs++; $display("FAIL a_only_ready got a=%b b=%b want 1 0", a_ready, b_ready); end
        checks++; if (add_valid_in !== 1'b1 || add_op1 !== 4'd3 || add_op2 !== 4'd4) begin errs++; $display("FAIL a_only_issue got v=%b op1=%0d op2=%0d want 1 3 4", add_valid_in, add_op1, add_op2); end
        tick();
        a_valid = 1'b0;
        checks++; if (a_resp_valid !== 1'b0 || busy !== 1'b1) begin errs++; $display("FAIL a_only_e0 got rv=%b busy=%b want 0 1", a_resp_valid, busy); end
        tick();
        checks++; if (a_resp_valid !== 1'b0) begin errs++; $display("FAIL a_only_e1 got rv=%b want 0", a_resp_valid); end
        tick();
        checks++; if (a_resp_valid !== 1'b1 || a_resp_sum !== 5'd7) begin errs++; $display("FAIL a_only_e2 got rv=%b sum=%0d want 1 7", a_resp_valid, a_resp_sum); end
        checks++; if (b_resp_valid !== 1'b0) begin errs++; $display("FAIL a_only_b got b_rv=%b want 0", b_resp_valid); end
        tick();
        checks++; if (a_resp_valid !== 1'b0 || a_resp_sum !== 5'd7 || busy !== 1'b0) begin errs++; $display("FAIL a_only_e3 got rv=%b sum=%0d busy=%b want 0 7 0", a_resp_valid, a_resp_sum, busy); end
    endtask

    task automatic test_contention();
        do_reset();
        a_valid = 1'b1; a_op1 = 4'd15; a_op2 = 4'd15;
        b_valid = 1'b1; b_op1 = 4'd1;  b_op2 = 4'd2;
        for (int k = 0; k < 10; k++) begin
            checks++; if (a_resp_valid !== (k >= 3 && k % 2 == 1)) begin errs++; $display("FAIL cont_a_rv k=%0d got %b", k, a_resp_valid); end
            if (k >= 3 && k % 2 == 1) begin
                checks++; if (a_resp_sum !== 5'd30) begin errs++; $display("FAIL cont_a_sum got %0d want 30", a_resp_sum); end
            end
            checks++; if (b_resp_valid !== (k >= 4 && k % 2 == 0)) begin errs++; $display("FAIL cont_b_rv k=%0d got %b", k, b_resp_valid); end
            if (k >= 4 && k % 2 == 0) begin
                checks++; if (b_resp_sum !== 5'd3) begin errs++; $display("FAIL cont_b_sum got %0d want 3", b_resp_sum); end
            end
            #1;
            checks++; if (a_ready !== (k % 2 == 0) || b_ready !== (k % 2 == 1)) begin errs++; $display("FAIL cont_grant k=%0d got a=%b b=%b want a=%b", k, a_ready, b_ready, k % 2 == 0); end
            checks++; if (add_op1 !== ((k % 2 == 0) ? 4'd15 : 4'd1)) begin errs++; $display("FAIL cont_op1 k=%0d got %0d", k, add_op1); end
            tick();
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic test_max_out();
        do_reset();
        a_valid = 1'b1; a_op1 = 4'd5; a_op2 = 4'd6;
        for (int k = 0; k < 8; k++) begin
            #1;
            checks++; if (a_ready !== 1'b1) begin errs++; $display("FAIL max_ready k=%0d got %b want 1", k, a_ready); end
            tick();
            checks++; if (dut.r_cnt_a !== ((k == 0) ? 2'd1 : 2'd2)) begin errs++; $display("FAIL max_cnt k=%0d got %0d want %0d", k, dut.r_cnt_a, (k == 0) ? 1 : 2); end
            checks++; if (a_resp_valid !== (k >= 2)) begin errs++; $display("FAIL max_rv k=%0d got %b", k, a_resp_valid); end
            if (k >= 2) begin
                checks++; if (a_resp_sum !== 5'd11) begin errs++; $display("FAIL max_sum got %0d want 11", a_resp_sum); end
            end
        end
        a_valid = 1'b0;
        tick(); tick(); tick();
        checks++; if (busy !== 1'b0 || dut.r_cnt_a !== 2'd0) begin errs++; $display("FAIL max_drain got busy=%b cnt=%0d want 0 0", busy, dut.r_cnt_a); end
    endtask

    task automatic test_max_out_one();
        do_reset();
        a_valid = 1'b1; a_op1 = 4'd1; a_op2 = 4'd1;
        b_valid = 1'b1; b_op1 = 4'd2; b_op2 = 4'd2;
        for (int k = 0; k < 9; k++) begin
            #1;
            checks++; if (m_a_ready !== (k % 3 == 0) || m_b_ready !== (k % 3 == 1)) begin errs++; $display("FAIL one_grant k=%0d got a=%b b=%b", k, m_a_ready, m_b_ready); end
            tick();
            if (k % 3 == 2) begin
                checks++; if (m_a_resp_valid !== 1'b1 || m_a_resp_sum !== 5'd2) begin errs++; $display("FAIL one_a_resp k=%0d got rv=%b sum=%0d want 1 2", k, m_a_resp_valid, m_a_resp_sum); end
            end
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic test_reset_midflight();
        do_reset();
        a_valid = 1'b1; a_op1 = 4'd2; a_op2 = 4'd2;
        tick();
        tick();
        a_valid = 1'b0;
        reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || a_resp_valid !== 1'b0) begin errs++; $display("FAIL mid_async got busy=%b rv=%b want 0 0", busy, a_resp_valid); end
        tick();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (a_resp_valid !== 1'b0 || b_resp_valid !== 1'b0 || busy !== 1'b0 || a_resp_sum !== 5'd0) begin errs++; $display("FAIL mid_quiet k=%0d got arv=%b brv=%b busy=%b sum=%0d", k, a_resp_valid, b_resp_valid, busy, a_resp_sum); end
        end
        a_valid = 1'b1;
        b_valid = 1'b1;
        #1;
        checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin errs++; $display("FAIL mid_tie got a=%b b=%b want 1 0", a_ready, b_ready); end
        a_valid = 1'b0;
        b_valid = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic [4:0] qa[$];
        logic [4:0] qb[$];
        logic fa, fb;
        logic [4:0] e;
        fa = 1'b0;
        fb = 1'b0;
        do_reset();
        for (int c = 0; c < 1012; c++) begin
            if (a_resp_valid) begin
                checks++;
                if (qa.size() == 0) begin errs++; $display("FAIL rnd_a_extra got sum=%0d with nothing pending", a_resp_sum); end
                else begin
                    e = qa.pop_front();
                    if (a_resp_sum !== e) begin errs++; $display("FAIL rnd_a_sum got %0d want %0d", a_resp_sum, e); end
                end
            end
            if (b_resp_valid) begin
                checks++;
                if (qb.size() == 0) begin errs++; $display("FAIL rnd_b_extra got sum=%0d with nothing pending", b_resp_sum); end
                else begin
                    e = qb.pop_front();
                    if (b_resp_sum !== e) begin errs++; $display("FAIL rnd_b_sum got %0d want %0d", b_resp_sum, e); end
                end
            end
            if (c >= 1000) begin
                a_valid = 1'b0;
                b_valid = 1'b0;
            end else begin
                if (!a_valid || fa) begin
                    a_valid = 1'($urandom_range(0, 1));
                    a_op1 = 4'($urandom);
                    a_op2 = 4'($urandom);
                end
                if (!b_valid || fb) begin
                    b_valid = 1'($urandom_range(0, 1));
                    b_op1 = 4'($urandom);
                    b_op2 = 4'($urandom);
                end
            end
            #1;
            checks++; if (a_ready && b_ready) begin errs++; $display("FAIL rnd_both_ready got a=1 b=1 want at most one"); end
            fa = a_valid && a_ready;
            fb = b_valid && b_ready;
            if (fa) qa.push_back(5'(a_op1) + 5'(a_op2));
            if (fb) qb.push_back(5'(b_op1) + 5'(b_op2));
            tick();
        end
        checks++; if (qa.size() != 0 || qb.size() != 0) begin errs++; $display("FAIL rnd_drain got pending a=%0d b=%0d want 0 0", qa.size(), qb.size()); end
    endtask

    initial begin
        test_reset();
        test_a_only();
        test_contention();
        test_max_out();
        test_max_out_one();
        test_reset_midflight();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
